// File: rtl/ir_pkg.sv
// Shared IR receiver definitions: key FSM states and default timing constants
// used by the frame decoder and the key event stage.
package ir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_SWITCH = 2'd2
  } key_state_e;

  // Defaults assume a 50 MHz system clock.
  localparam int HOLD_CYCLES_DEF      = 25_000_000;
  localparam int RATE_CYCLES_DEF      = 5_000_000;
  localparam int RELEASE_CYCLES_DEF   = 12_000_000;
  localparam int BIT_THRESHOLD_CYCLES = 84_375;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ir_timer.sv
// Loadable down-counter that holds at 0. `zero` flags the edge on which a
// running count steps from 1 to 0, so the owner can react in that same edge.
module ir_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         run,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = run && (cnt_q == W'(1));

endmodule

// File: rtl/ir_key_events.sv
// Turns checked IR frames into press / auto-repeat / release key events and
// keeps a saturating count plus a sticky flag for rejected frames.
module ir_key_events
  import ir_pkg::*;
#(
  parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int RATE_CYCLES    = RATE_CYCLES_DEF,
  parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_valid,
  input  logic [7:0] comando,
  input  logic [7:0] comparador,
  output logic [7:0] key_code,
  output logic       key_press,
  output logic       key_repeat,
  output logic       key_release,
  output logic       key_held,
  output logic [7:0] err_count,
  output logic       err_flag
);

  localparam int MAXP = max3(HOLD_CYCLES, RATE_CYCLES, RELEASE_CYCLES);
  localparam int TW   = $clog2(MAXP) + 1;

  // Valid/ready: there is no backpressure; frame_valid is a one-cycle strobe
  // and comando/comparador are only meaningful while it is high.
  key_state_e state_q, state_d;
  logic [7:0] key_code_q, key_code_d;
  logic [7:0] pend_code_q, pend_code_d;
  logic       press_q, press_d;
  logic       repeat_q, repeat_d;
  logic       release_q, release_d;
  logic       held_q, held_d;
  logic [7:0] err_count_q, err_count_d;
  logic       err_flag_q, err_flag_d;

  logic          frame_ok, frame_bad, timers_run;
  logic          rep_load, rel_load, rep_zero, rel_zero;
  logic [TW-1:0] rep_value;

  assign frame_ok   = frame_valid && (comando == ~comparador);
  assign frame_bad  = frame_valid && (comando != ~comparador);
  assign timers_run = (state_q == ST_HELD);

  ir_timer #(.W(TW)) u_rep_timer (
    .clk(clk), .rst(reset), .load(rep_load), .value(rep_value),
    .run(timers_run), .zero(rep_zero)
  );

  ir_timer #(.W(TW)) u_rel_timer (
    .clk(clk), .rst(reset), .load(rel_load), .value(TW'(RELEASE_CYCLES)),
    .run(timers_run), .zero(rel_zero)
  );

  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    pend_code_d = pend_code_q;
    press_d     = 1'b0;
    repeat_d    = 1'b0;
    release_d   = 1'b0;
    rep_load    = 1'b0;
    rel_load    = 1'b0;
    rep_value   = TW'(HOLD_CYCLES);
    case (state_q)
      ST_IDLE: begin
        if (frame_ok) begin
          key_code_d = comando;
          press_d    = 1'b1;
          rep_load   = 1'b1;
          rel_load   = 1'b1;
          state_d    = ST_HELD;
        end
      end
      ST_HELD: begin
        // A matching frame beats release expiry; a new code beats both timers.
        if (frame_ok && (comando == key_code_q)) begin
          rel_load = 1'b1;
          if (rep_zero) begin
            repeat_d  = 1'b1;
            rep_load  = 1'b1;
            rep_value = TW'(RATE_CYCLES);
          end
        end else if (frame_ok) begin
          release_d   = 1'b1;
          pend_code_d = comando;
          state_d     = ST_SWITCH;
        end else if (rel_zero) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (rep_zero) begin
          repeat_d  = 1'b1;
          rep_load  = 1'b1;
          rep_value = TW'(RATE_CYCLES);
        end
      end
      ST_SWITCH: begin
        key_code_d = pend_code_q;
        press_d    = 1'b1;
        rep_load   = 1'b1;
        rel_load   = 1'b1;
        state_d    = ST_HELD;
      end
      default: state_d = ST_IDLE;
    endcase

    held_d      = (state_d != ST_IDLE);
    err_count_d = (frame_bad && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
    err_flag_d  = err_flag_q | frame_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      key_code_q  <= 8'd0;
      pend_code_q <= 8'd0;
      press_q     <= 1'b0;
      repeat_q    <= 1'b0;
      release_q   <= 1'b0;
      held_q      <= 1'b0;
      err_count_q <= 8'd0;
      err_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      pend_code_q <= pend_code_d;
      press_q     <= press_d;
      repeat_q    <= repeat_d;
      release_q   <= release_d;
      held_q      <= held_d;
      err_count_q <= err_count_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_press   = press_q;
  assign key_repeat  = repeat_q;
  assign key_release = release_q;
  assign key_held    = held_q;
  assign err_count   = err_count_q;
  assign err_flag    = err_flag_q;

endmodule

// File: tb/tb_ir_key_events.sv
// Bench for ir_key_events: frame table, hand-built corner sequences and random
// traffic, all checked each cycle against a deadline-based reference model.
module tb_ir_key_events;

  localparam int HOLD = 20;
  localparam int RATE = 5;
  localparam int REL  = 30;
  localparam int OW   = 21;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_valid;
  logic [7:0] comando, comparador;
  logic [7:0] key_code, err_count;
  logic       key_press, key_repeat, key_release, key_held, err_flag;

  always #5 clk = ~clk;

  ir_key_events #(.HOLD_CYCLES(HOLD), .RATE_CYCLES(RATE), .RELEASE_CYCLES(REL)) dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .comando(comando),
    .comparador(comparador), .key_code(key_code), .key_press(key_press),
    .key_repeat(key_repeat), .key_release(key_release), .key_held(key_held),
    .err_count(err_count), .err_flag(err_flag)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: key status plus absolute cycle deadlines for events.
  bit         m_held, m_switch;
  logic [7:0] m_code, m_pend;
  int         rep_due, rel_due, m_err;
  bit         m_flag;
  logic [OW-1:0] exp_q[$];

  // Event log gathered from observed outputs for the sequence checks.
  int press_cnt, rep_cnt, rel_cnt, press_at, first_rep_at, rel_at;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [OW-1:0] outs_now();
    return {key_code, key_press, key_repeat, key_release, key_held, err_count, err_flag};
  endfunction

  task automatic model_reset();
    m_held = 0; m_switch = 0; m_code = 8'd0; m_pend = 8'd0;
    rep_due = -1; rel_due = -1; m_err = 0; m_flag = 0;
  endtask

  task automatic model_step(input logic fv, input logic [7:0] c, input logic [7:0] p);
    int  t;
    bit  ok, pr, rp, rl;
    t = cyc + 1;
    pr = 0; rp = 0; rl = 0;
    ok = fv && (c == ~p);
    if (fv && !ok) begin
      m_err  = (m_err < 255) ? m_err + 1 : 255;
      m_flag = 1;
    end
    if (m_switch) begin
      m_switch = 0; m_code = m_pend; pr = 1;
      rep_due = t + HOLD; rel_due = t + REL;
    end else if (!m_held) begin
      if (ok) begin
        m_held = 1; m_code = c; pr = 1;
        rep_due = t + HOLD; rel_due = t + REL;
      end
    end else if (ok && c == m_code) begin
      rel_due = t + REL;
      if (rep_due == t) begin rp = 1; rep_due = t + RATE; end
    end else if (ok) begin
      rl = 1; m_pend = c; m_switch = 1;
    end else if (rel_due == t) begin
      rl = 1; m_held = 0;
    end else if (rep_due == t) begin
      rp = 1; rep_due = t + RATE;
    end
    exp_q.push_back({m_code, pr, rp, rl, m_held, m_err[7:0], m_flag});
  endtask

  task automatic clear_log();
    press_cnt = 0; rep_cnt = 0; rel_cnt = 0;
    press_at = -1; first_rep_at = -1; rel_at = -1;
  endtask

  // Drive one cycle of input, then compare the registered response.
  task automatic cycle(input logic fv, input logic [7:0] c, input logic [7:0] p);
    logic [OW-1:0] expv;
    frame_valid = fv; comando = c; comparador = p;
    model_step(fv, c, p);
    @(posedge clk); #1;
    cyc++;
    expv = exp_q.pop_front();
    check("outputs", 32'(outs_now()), 32'(expv));
    if (key_press)   begin press_cnt++; press_at = cyc; end
    if (key_repeat)  begin rep_cnt++; if (first_rep_at < 0) first_rep_at = cyc; end
    if (key_release) begin rel_cnt++; rel_at = cyc; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00);
  endtask

  // Asynchronous reset raised between edges; outputs must clear before any edge.
  task automatic do_reset();
    frame_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_async", 32'(outs_now()), 32'd0);
    model_reset();
    @(posedge clk); #1;
    cyc++;
    reset = 1'b0;
    check("reset_hold", 32'(outs_now()), 32'd0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] cmp;
    logic       exp_press;
    logic [7:0] exp_err;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'h45, 8'hBA, 1'b1, 8'd0};
    tbl[1] = '{8'h45, 8'h00, 1'b0, 8'd1};
    tbl[2] = '{8'h00, 8'hFF, 1'b1, 8'd0};
    tbl[3] = '{8'hFF, 8'h00, 1'b1, 8'd0};
    tbl[4] = '{8'h16, 8'hE9, 1'b1, 8'd0};
    tbl[5] = '{8'h16, 8'h16, 1'b0, 8'd1};
    tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'd0};
    tbl[7] = '{8'h12, 8'h34, 1'b0, 8'd1};

    reset = 1'b1; frame_valid = 1'b0; comando = 8'h00; comparador = 8'h00;
    model_reset();
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", 32'(outs_now()), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_reset();
      cycle(1'b1, tbl[i].cmd, tbl[i].cmp);
      check("tbl_press", 32'(key_press), 32'(tbl[i].exp_press));
      check("tbl_err", 32'(err_count), 32'(tbl[i].exp_err));
      check("tbl_code", 32'(key_code), tbl[i].exp_press ? 32'(tbl[i].cmd) : 32'd0);
      idle(3);
    end

    // Single frame: repeats at +20 and +25, release at +30 wins over the +30 repeat.
    do_reset(); clear_log();
    cycle(1'b1, 8'h45, 8'hBA);
    check("single_code", 32'(key_code), 32'h45);
    idle(40);
    check("single_press_cnt", 32'(press_cnt), 32'd1);
    check("single_rep_cnt", 32'(rep_cnt), 32'd2);
    check("single_first_rep", 32'(first_rep_at - press_at), 32'd20);
    check("single_rel_delay", 32'(rel_at - press_at), 32'd30);

    // Held key: frames every 10 cycles over 60 cycles.
    do_reset(); clear_log();
    for (int i = 0; i <= 60; i++) cycle(i % 10 == 0, 8'h45, 8'hBA);
    idle(40);
    check("held_press_cnt", 32'(press_cnt), 32'd1);
    check("held_first_rep", 32'(first_rep_at - press_at), 32'd20);
    check("held_rep_cnt", 32'(rep_cnt), 32'd14);
    check("held_rel_cnt", 32'(rel_cnt), 32'd1);
    check("held_rel_delay", 32'(rel_at - press_at), 32'd90);

    // Rejected frames and saturation.
    do_reset(); clear_log();
    cycle(1'b1, 8'h45, 8'h00);
    check("err_one", 32'(err_count), 32'd1);
    check("err_flag", 32'(err_flag), 32'd1);
    check("err_no_press", 32'(key_press | key_held), 32'd0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'h45, 8'h00);
    check("err_sat", 32'(err_count), 32'd255);

    // Code change while held, with frames arriving during the switch.
    do_reset(); clear_log();
    cycle(1'b1, 8'h45, 8'hBA);
    idle(3);
    cycle(1'b1, 8'h16, 8'hE9);
    check("sw_release", 32'(key_release), 32'd1);
    check("sw_old_code", 32'(key_code), 32'h45);
    cycle(1'b1, 8'h77, 8'h00);
    check("sw_press", 32'(key_press), 32'd1);
    check("sw_new_code", 32'(key_code), 32'h16);
    check("sw_err_counted", 32'(err_count), 32'd1);
    cycle(1'b0, 8'h00, 8'h00);
    idle(35);

    // Matching frame exactly when the release timer expires (also a repeat slot).
    do_reset(); clear_log();
    cycle(1'b1, 8'h45, 8'hBA);
    idle(29);
    cycle(1'b1, 8'h45, 8'hBA);
    check("edge_no_release", 32'(key_release), 32'd0);
    check("edge_held", 32'(key_held), 32'd1);
    check("edge_repeat", 32'(key_repeat), 32'd1);
    idle(5);

    // Reset mid-hold, then a normal press.
    clear_log();
    check("pre_reset_held", 32'(key_held), 32'd1);
    do_reset();
    check("rst_no_release", 32'(rel_cnt), 32'd0);
    cycle(1'b1, 8'h0C, 8'hF3);
    check("post_rst_press", 32'(key_press), 32'd1);
    check("post_rst_code", 32'(key_code), 32'h0C);
    idle(40);

    // Random traffic in blocks of varying frame density.
    for (int blk = 0; blk < 20; blk++) begin
      int dens;
      if (blk % 5 == 0) do_reset();
      dens = $urandom_range(2, 20);
      for (int i = 0; i < 150; i++) begin
        logic [7:0] c, p;
        logic       fv;
        case ($urandom_range(0, 2))
          0: c = 8'h45;
          1: c = 8'h16;
          default: c = 8'h0C;
        endcase
        p  = ($urandom_range(0, 99) < 20) ? 8'($urandom_range(0, 255)) : ~c;
        fv = ($urandom_range(0, 99) < dens);
        cycle(fv, c, p);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
